serial_add_seq: RTL
===================

Name: serial_add_seq

Overview:
- Bit-serial adder sequencer: accepts two WIDTH-bit operands via valid/ready and adds them LSB-first, one bit per cycle, through a single-bit full-add cell built from two half adders plus an OR.
- A registered carry links successive bits. The result is presented with a valid/ready output handshake.
- Upstream feeder and downstream consumer of the half-adder datapath: it sequences operands into the one-bit add cell and assembles what that cell produces.

Parameters:
WIDTH, 8, operand and result width in bits (>=2)
CW, $clog2(WIDTH), bit-counter width (derived, not overridable)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands a/b valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  sum/cout valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  A+B modulo 2^WIDTH
cout  output  1  carry out of bit WIDTH-1
busy  output  1  high whenever state != IDLE

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset values (rst sampled high at clk edge):
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - sum=0, cout=0, carry reg=0, bit counter=0, operand shift regs=0.
- rst overrides every other input, including mid-RUN or mid-DONE; an in-flight operation is discarded with no output.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, load a->A shift reg, b->B shift reg, carry=0, cnt=0, sum reg=0, go RUN.
  - RUN: in_ready=0; in_valid is ignored. Each cycle:
    - s = A[0]^B[0]^carry.
    - c = (A[0]&B[0]) | ((A[0]^B[0])&carry).
    - Shift A and B right by 1.
    - Shift s into sum reg MSB (sum reg shifts right).
    - carry<=c, cnt<=cnt+1.
    - When cnt==WIDTH-1 (last bit), next state DONE and cout<=c.
  - DONE: out_valid=1; sum/cout held stable. On out_ready, go IDLE (out_valid drops next cycle).
- Latency: acceptance at edge k; RUN occupies edges k+1..k+WIDTH; out_valid is high from cycle after edge k+WIDTH. For WIDTH=8, out_valid is first seen 8 cycles after the accept cycle.
- Throughput: one operation per WIDTH+2 cycles minimum (accept, WIDTH RUN, DONE handshake). No overlap of accept and output.
- out_valid, once high, stays high with stable sum/cout until out_ready is sampled high. No retraction.
- in_ready depends only on state; no combinational path from out_ready to in_ready.
- sum/cout retain the last result after leaving DONE until the next completion or reset. They are meaningful only while out_valid.
- Arithmetic: unsigned modulo 2^WIDTH; overflow reported only via cout.
- Counter: CW bits; compare against WIDTH-1, so it must never wrap within an operation.

Decomposition:
- Shared package serial_add_pkg:
  - state enum {IDLE, RUN, DONE} (2-bit encoding 00/01/10).
  - Localparam for default WIDTH.
- One sub-module, bit_full_add: combinational full adder (a, b, cin -> s, cout) built from two half-adder instances plus an OR gate. It reuses the team's half-adder cell unchanged.
- The sequencer holds all sequential state.

Test Plan:
- Basic add: WIDTH=8, a=8'h3C, b=8'h42, out_ready=1 -> out_valid 8 cycles after accept, sum=8'h7E, cout=0, busy high throughout.
- Carry ripple/overflow: a=8'hFF, b=8'h01 -> sum=8'h00, cout=1; then a=8'hFF, b=8'hFF -> sum=8'hFE, cout=1.
- Backpressure: a=8'h10, b=8'h20, out_ready=0 for 5 cycles after out_valid:
  - out_valid stays 1, sum=8'h30 stable, in_ready=0.
  - Raising out_ready returns to IDLE next cycle, in_ready=1.
- Ignored input during RUN: accept a=8'h01, b=8'h02; pulse in_valid with a=8'hAA, b=8'h55 during RUN -> result sum=8'h03, and the second pair is not accepted (in_ready=0 throughout).
- Reset mid-operation: accept a=8'h80, b=8'h80; assert rst at RUN cycle 4 -> next cycle state IDLE, out_valid=0, sum=0, cout=0, in_ready=1. A fresh a=8'h05, b=8'h03 then yields sum=8'h08.
- Back-to-back: in_valid held high with 3 operand pairs, out_ready=1 -> each result is correct and each accept occurs exactly WIDTH+2 cycles apart.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder sequencer.
package serial_add_pkg;
   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;
endpackage

// File: rtl/half_add.sv
// One-bit half adder cell.
module half_add (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);
   assign s = a ^ b;
   assign c = a & b;
endmodule

// File: rtl/serial_add_seq_bit_full_add.sv
// Combinational one-bit full adder: two half adders chained, carries ORed.
module bit_full_add (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   logic s0, c0, c1;

   half_add u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
   half_add u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

   assign cout = c0 | c1;
endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial adder: accepts A/B, adds LSB-first one bit per cycle, then holds
// the result under a valid/ready handshake.
module serial_add_seq
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e          state;
   logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_q;
   logic            carry, cout_q;
   logic [CW-1:0]   cnt;
   logic            bit_s, bit_c;

   bit_full_add u_fa (
      .a   (a_sr[0]),
      .b   (b_sr[0]),
      .cin (carry),
      .s   (bit_s),
      .cout(bit_c)
   );

   // Handshake outputs are pure functions of state.
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign sum       = sum_q;
   assign cout      = cout_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         sum_q  <= '0;
         carry  <= 1'b0;
         cout_q <= 1'b0;
         cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sr   <= a;
                  b_sr   <= b;
                  sum_sr <= '0;
                  carry  <= 1'b0;
                  cnt    <= '0;
                  state  <= RUN;
               end
            end
            RUN: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               sum_sr <= {bit_s, sum_sr[WIDTH-1:1]};
               carry  <= bit_c;
               cnt    <= cnt + CW'(1);
               // Result register is separate so sum stays put between operations.
               if (cnt == LAST) begin
                  sum_q  <= {bit_s, sum_sr[WIDTH-1:1]};
                  cout_q <= bit_c;
                  state  <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
